// File: rtl/aclock_ctrl.sv
// Front-panel sequencer for the alarm clock core: digit editing, timed load/stop
// strobes to the core, and snooze by temporarily reprogramming the core's alarm.
module aclock_ctrl #(
  parameter int unsigned LD_HOLD    = 12,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic       btn_snooze,
  input  logic       al_toggle,
  input  logic       Alarm,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] edit_mode,
  output logic [1:0] edit_digit,
  output logic       busy
);

  localparam int unsigned   HW        = $clog2(LD_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LD_HOLD - 1);
  localparam logic [3:0]    SNZ_M0    = 4'(SNOOZE_MIN % 10);
  localparam logic [3:0]    SNZ_M1    = 4'(SNOOZE_MIN / 10);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_T, S_EDIT_A, S_LOAD_T, S_LOAD_A, S_STOP
  } state_e;

  state_e        state_q;
  logic [1:0]    e_h1_q, s_h1_q;
  logic [3:0]    e_h0_q, e_m1_q, e_m0_q;
  logic [3:0]    s_h0_q, s_m1_q, s_m0_q;
  logic          snoozed_q, stop_snz_q;
  logic [HW-1:0] hcnt_q;
  logic [1:0]    digit_q;
  logic          ld_time_q, ld_alarm_q, stop_al_q, al_on_q;

  logic [1:0] inc_h1_d;
  logic [3:0] inc_h0_d, inc_m1_d, inc_m0_d;
  logic [1:0] snz_h1_d;
  logic [3:0] snz_h0_d, snz_m1_d, snz_m0_d;
  logic [4:0] snz_m0_sum;
  logic [3:0] snz_m1_sum, snz_h0_sum;
  logic       snz_c0, snz_c1;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inc_h1_d = e_h1_q;
    inc_h0_d = e_h0_q;
    inc_m1_d = e_m1_q;
    inc_m0_d = e_m0_q;
    unique case (digit_q)
      2'd0: begin
        inc_h1_d = (e_h1_q >= 2'd2) ? 2'd0 : e_h1_q + 2'd1;
        if (e_h1_q == 2'd1 && e_h0_q > 4'd3) inc_h0_d = 4'd3;
      end
      2'd1: inc_h0_d = (e_h0_q >= ((e_h1_q == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : e_h0_q + 4'd1;
      2'd2: inc_m1_d = (e_m1_q >= 4'd5) ? 4'd0 : e_m1_q + 4'd1;
      2'd3: inc_m0_d = (e_m0_q >= 4'd9) ? 4'd0 : e_m0_q + 4'd1;
    endcase
  end

  // Snooze target computed digit-wise in BCD with decimal carries.
  always_comb begin
    snz_m0_sum = {1'b0, M_out0} + {1'b0, SNZ_M0};
    snz_c0     = (snz_m0_sum >= 5'd10);
    snz_m0_d   = snz_c0 ? snz_m0_sum[3:0] + 4'd6 : snz_m0_sum[3:0];
    snz_m1_sum = M_out1 + SNZ_M1 + {3'd0, snz_c0};
    snz_c1     = (snz_m1_sum >= 4'd6);
    snz_m1_d   = snz_c1 ? snz_m1_sum - 4'd6 : snz_m1_sum;
    snz_h0_sum = H_out0 + {3'd0, snz_c1};
    snz_h1_d   = H_out1;
    snz_h0_d   = snz_h0_sum;
    if (snz_h0_sum >= 4'd10) begin
      snz_h0_d = 4'd0;
      snz_h1_d = H_out1 + 2'd1;
    end
    if (snz_h1_d == 2'd2 && snz_h0_d == 4'd4) begin
      snz_h1_d = 2'd0;
      snz_h0_d = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      e_h1_q     <= '0;
      e_h0_q     <= '0;
      e_m1_q     <= '0;
      e_m0_q     <= '0;
      s_h1_q     <= '0;
      s_h0_q     <= '0;
      s_m1_q     <= '0;
      s_m0_q     <= '0;
      snoozed_q  <= 1'b0;
      stop_snz_q <= 1'b0;
      hcnt_q     <= '0;
      digit_q    <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      stop_al_q  <= 1'b0;
      al_on_q    <= 1'b0;
    end else begin
      if (al_toggle) al_on_q <= ~al_on_q;
      unique case (state_q)
        S_IDLE: begin
          if (btn_snooze && Alarm) begin
            e_h1_q     <= snz_h1_d;
            e_h0_q     <= snz_h0_d;
            e_m1_q     <= snz_m1_d;
            e_m0_q     <= snz_m0_d;
            snoozed_q  <= 1'b1;
            stop_snz_q <= 1'b1;
            hcnt_q     <= '0;
            stop_al_q  <= 1'b1;
            state_q    <= S_STOP;
          end else if (btn_set && Alarm) begin
            stop_snz_q <= 1'b0;
            hcnt_q     <= '0;
            stop_al_q  <= 1'b1;
            state_q    <= S_STOP;
          end else if (btn_mode) begin
            e_h1_q  <= H_out1;
            e_h0_q  <= H_out0;
            e_m1_q  <= M_out1;
            e_m0_q  <= M_out0;
            digit_q <= 2'd0;
            state_q <= S_EDIT_T;
          end
        end
        S_EDIT_T, S_EDIT_A: begin
          if (btn_mode) begin
            digit_q <= 2'd0;
            if (state_q == S_EDIT_T) begin
              e_h1_q  <= s_h1_q;
              e_h0_q  <= s_h0_q;
              e_m1_q  <= s_m1_q;
              e_m0_q  <= s_m0_q;
              state_q <= S_EDIT_A;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (btn_set) begin
            digit_q <= digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              hcnt_q <= '0;
              if (state_q == S_EDIT_T) begin
                ld_time_q <= 1'b1;
                state_q   <= S_LOAD_T;
              end else begin
                s_h1_q     <= e_h1_q;
                s_h0_q     <= e_h0_q;
                s_m1_q     <= e_m1_q;
                s_m0_q     <= e_m0_q;
                snoozed_q  <= 1'b0;
                ld_alarm_q <= 1'b1;
                state_q    <= S_LOAD_A;
              end
            end
          end else if (btn_inc) begin
            e_h1_q <= inc_h1_d;
            e_h0_q <= inc_h0_d;
            e_m1_q <= inc_m1_d;
            e_m0_q <= inc_m0_d;
          end
        end
        S_LOAD_T, S_LOAD_A: begin
          if (hcnt_q == HOLD_LAST) begin
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        S_STOP: begin
          if (hcnt_q == HOLD_LAST) begin
            stop_al_q <= 1'b0;
            hcnt_q    <= '0;
            if (stop_snz_q) begin
              ld_alarm_q <= 1'b1;
              state_q    <= S_LOAD_A;
            end else if (snoozed_q) begin
              // Undo the snooze: put the user's alarm back into the core.
              e_h1_q     <= s_h1_q;
              e_h0_q     <= s_h0_q;
              e_m1_q     <= s_m1_q;
              e_m0_q     <= s_m0_q;
              snoozed_q  <= 1'b0;
              ld_alarm_q <= 1'b1;
              state_q    <= S_LOAD_A;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    edit_mode = 2'd0;
    busy      = 1'b0;
    unique case (state_q)
      S_EDIT_T:                   edit_mode = 2'd1;
      S_EDIT_A:                   edit_mode = 2'd2;
      S_LOAD_T, S_LOAD_A, S_STOP: busy      = 1'b1;
      default:                    ;
    endcase
  end

  assign H_in1      = e_h1_q;
  assign H_in0      = e_h0_q;
  assign M_in1      = e_m1_q;
  assign M_in0      = e_m0_q;
  assign LD_time    = ld_time_q;
  assign LD_alarm   = ld_alarm_q;
  assign STOP_al    = stop_al_q;
  assign AL_ON      = al_on_q;
  assign edit_digit = digit_q;

endmodule

// File: tb/tb_aclock_ctrl.sv
// Scoreboard bench for aclock_ctrl: expected strobes are queued by the stimulus
// and matched by a monitor that measures every strobe pulse the DUT emits.
module tb_aclock_ctrl;
  localparam int LD_HOLD    = 12;
  localparam int SNOOZE_MIN = 5;

  localparam logic [2:0] K_LDT  = 3'b100;
  localparam logic [2:0] K_LDA  = 3'b010;
  localparam logic [2:0] K_STOP = 3'b001;

  logic       clk, reset;
  logic       btn_mode, btn_inc, btn_set, btn_snooze, al_toggle, Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, busy;
  logic [1:0] edit_mode, edit_digit;
  logic [13:0] h_in_all;

  assign h_in_all = {H_in1, H_in0, M_in1, M_in0};

  aclock_ctrl #(.LD_HOLD(LD_HOLD), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set),
    .btn_snooze(btn_snooze), .al_toggle(al_toggle), .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .edit_mode(edit_mode), .edit_digit(edit_digit), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0]  kind;
    logic [13:0] vals;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual,
                  expected, expected);
  endtask

  function automatic logic [13:0] bcd(input int h1, input int h0, input int m1, input int m0);
    return {2'(h1), 4'(h0), 4'(m1), 4'(m0)};
  endfunction

  task automatic expect_strobe(input logic [2:0] k, input logic [13:0] v);
    exp_t e;
    e.kind = k;
    e.vals = v;
    exp_q.push_back(e);
  endtask

  task automatic press(input bit m, input bit i, input bit s, input bit z, input bit t);
    @(posedge clk);
    #1;
    btn_mode = m; btn_inc = i; btn_set = s; btn_snooze = z; al_toggle = t;
    @(posedge clk);
    #1;
    btn_mode = 0; btn_inc = 0; btn_set = 0; btn_snooze = 0; al_toggle = 0;
  endtask

  task automatic mode_p();
    press(1, 0, 0, 0, 0);
  endtask

  task automatic inc_n(input int n);
    repeat (n) press(0, 1, 0, 0, 0);
  endtask

  task automatic set_n(input int n);
    repeat (n) press(0, 0, 1, 0, 0);
  endtask

  task automatic set_time(input int h1, input int h0, input int m1, input int m0);
    {H_out1, H_out0, M_out1, M_out0} = bcd(h1, h0, m1, m0);
  endtask

  // Counts rising edges until busy drops; a blown budget shows up as a failed check.
  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_idle"}, int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [2:0]  strobes, cur_kind;
    logic [13:0] cur_vals;
    int          cur_len;
    bit          in_pulse, stable;
    exp_t        e;
    in_pulse = 0;
    stable   = 1;
    cur_len  = 0;
    cur_kind = '0;
    cur_vals = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        in_pulse = 0;
      end else begin
        strobes = {LD_time, LD_alarm, STOP_al};
        if (in_pulse && strobes == cur_kind) begin
          cur_len++;
          if (h_in_all != cur_vals) stable = 0;
        end else begin
          if (in_pulse) begin
            if (exp_q.size() == 0) begin
              check("unexpected_strobe", int'(cur_kind), 0);
            end else begin
              e = exp_q.pop_front();
              check("strobe_kind", int'(cur_kind), int'(e.kind));
              check("strobe_vals", int'(cur_vals), int'(e.vals));
              check("strobe_len", cur_len, LD_HOLD);
              check("strobe_stable", int'(stable), 1);
            end
          end
          in_pulse = (strobes != 3'b000);
          if (in_pulse) begin
            cur_kind = strobes;
            cur_vals = h_in_all;
            cur_len  = 1;
            stable   = 1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc;
    reset = 1'b1;
    btn_mode = 0; btn_inc = 0; btn_set = 0; btn_snooze = 0; al_toggle = 0; Alarm = 0;
    set_time(0, 0, 0, 0);
    #2 reset = 1'b0;
    #5;
    check("rst_strobes", int'({LD_time, LD_alarm, STOP_al}), 0);
    check("rst_h_in", int'(h_in_all), 0);
    check("rst_al_on", int'(AL_ON), 0);
    check("rst_mode_busy", int'({edit_mode, edit_digit, busy}), 0);
    @(negedge clk);
    reset = 1'b1;

    // Time set 00:00 with no edits.
    mode_p();
    check("edit_t_mode", int'(edit_mode), 1);
    set_n(3);
    check("edit_digit3", int'(edit_digit), 3);
    expect_strobe(K_LDT, bcd(0, 0, 0, 0));
    set_n(1);
    check("ldt_busy", int'(busy), 1);
    wait_idle("ldt0", cyc);
    check("ldt_latency", cyc, LD_HOLD);

    // Time set to 23:59.
    mode_p();
    inc_n(2);
    set_n(1);
    inc_n(3);
    set_n(1);
    inc_n(5);
    set_n(1);
    inc_n(9);
    check("edit_2359", int'(h_in_all), int'(bcd(2, 3, 5, 9)));
    expect_strobe(K_LDT, bcd(2, 3, 5, 9));
    set_n(1);
    wait_idle("ldt2359", cyc);

    // Wrap and clamp rules, then abandon through the alarm page.
    set_time(1, 7, 5, 0);
    mode_p();
    check("capture", int'(h_in_all), int'(bcd(1, 7, 5, 0)));
    inc_n(1);
    check("h1_clamp", int'({H_in1, H_in0}), int'({2'd2, 4'd3}));
    inc_n(1);
    check("h1_wrap", int'(H_in1), 0);
    inc_n(2);
    set_n(1);
    check("edit_digit1", int'(edit_digit), 1);
    inc_n(1);
    check("h0_wrap_h1_2", int'(H_in0), 0);
    set_n(1);
    inc_n(1);
    check("m1_wrap", int'(M_in1), 0);
    mode_p();
    check("edit_a_mode", int'(edit_mode), 2);
    check("edit_a_shadow0", int'(h_in_all), 0);
    mode_p();
    check("abandon_idle", int'({edit_mode, busy}), 0);

    // Alarm set to 07:30.
    mode_p();
    mode_p();
    set_n(1);
    inc_n(7);
    set_n(1);
    inc_n(3);
    set_n(1);
    expect_strobe(K_LDA, bcd(0, 7, 3, 0));
    set_n(1);
    wait_idle("lda0730", cyc);
    mode_p();
    mode_p();
    check("shadow_updated", int'(h_in_all), int'(bcd(0, 7, 3, 0)));
    inc_n(1);
    check("alarm_edit_h1", int'(H_in1), 1);
    mode_p();
    mode_p();
    mode_p();
    check("shadow_kept", int'(h_in_all), int'(bcd(0, 7, 3, 0)));
    mode_p();

    // Snooze at 23:58 (snooze and set together: snooze wins) -> alarm 00:03.
    set_time(2, 3, 5, 8);
    Alarm = 1'b1;
    expect_strobe(K_STOP, bcd(0, 0, 0, 3));
    expect_strobe(K_LDA, bcd(0, 0, 0, 3));
    press(0, 0, 1, 1, 0);
    Alarm = 1'b0;
    check("snz_stop", int'(STOP_al), 1);
    wait_idle("snooze", cyc);
    check("snz_latency", cyc, 2 * LD_HOLD);

    // Stop while snoozed restores the user alarm.
    set_time(0, 0, 0, 3);
    Alarm = 1'b1;
    expect_strobe(K_STOP, bcd(0, 0, 0, 3));
    expect_strobe(K_LDA, bcd(0, 7, 3, 0));
    press(0, 0, 1, 0, 0);
    Alarm = 1'b0;
    wait_idle("restore", cyc);
    check("restore_latency", cyc, 2 * LD_HOLD);
    check("restore_h_in", int'(h_in_all), int'(bcd(0, 7, 3, 0)));

    // Snoozed flag cleared: a plain stop has no reload.
    Alarm = 1'b1;
    expect_strobe(K_STOP, bcd(0, 7, 3, 0));
    press(0, 0, 1, 0, 0);
    Alarm = 1'b0;
    wait_idle("stop_only", cyc);
    check("stop_only_latency", cyc, LD_HOLD);

    // Alarm toggle during a time load.
    set_time(1, 2, 3, 4);
    mode_p();
    set_n(3);
    expect_strobe(K_LDT, bcd(1, 2, 3, 4));
    set_n(1);
    press(0, 0, 0, 0, 1);
    check("toggle_al_on", int'(AL_ON), 1);
    check("toggle_ld_time", int'(LD_time), 1);
    wait_idle("toggle", cyc);

    // Reset in the middle of a strobe.
    mode_p();
    set_n(4);
    check("pre_rst_ld_time", int'(LD_time), 1);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_strobes", int'({LD_time, LD_alarm, STOP_al}), 0);
    check("midrst_state", int'({busy, edit_mode}), 0);
    check("midrst_al_on", int'(AL_ON), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_quiet", int'({LD_time, LD_alarm, STOP_al, busy}), 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aclock_ctrl.md
# aclock_ctrl

User-interface sequencer for the alarm clock core. It turns four debounced push-button pulses and an alarm-enable toggle into digit edits, and emits timed `LD_time`/`LD_alarm`/`STOP_al` strobes with the matching `H_in*`/`M_in*` values. It also implements snooze by reprogramming the core's single alarm register and restoring the user alarm afterwards. It sits between the front-panel debouncers and the clock core, on the core's fast `clk` domain.

## Interface
- `LD_HOLD`, 12: cycles each load/stop strobe is held. Must be ≥ 11 so that the strobe spans at least one rising edge of the core's 1 s tick (10 `clk` period).
- `SNOOZE_MIN`, 5: snooze offset in minutes. Legal range 1..59.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous and active-low.
- `btn_mode`, `btn_inc`, `btn_set`, `btn_snooze` in 1 each: single-cycle debounced button pulses.
- `al_toggle` in 1: single-cycle pulse that toggles `AL_ON`.
- `Alarm` in 1: core alarm output.
- `H_out1` in 2, `H_out0` in 4, `M_out1` in 4, `M_out0` in 4: current core time (BCD).
- `H_in1` out 2, `H_in0` out 4, `M_in1` out 4, `M_in0` out 4: load value (BCD) driven to the core.
- `LD_time`, `LD_alarm`, `STOP_al` out 1 each: held strobes to the core.
- `AL_ON` out 1: alarm enable.
- `edit_mode` out 2: 0 = none, 1 = time, 2 = alarm.
- `edit_digit` out 2: digit under edit; 0 = H1, 1 = H0, 2 = M1, 3 = M0.
- `busy` out 1: high in LOAD_T, LOAD_A and STOP.

## Operation
- **Internal registers:** edit digits `e_h1`, `e_h0`, `e_m1`, `e_m0`; alarm shadow `s_h1`..`s_m0` (the core cannot read its alarm back); `snoozed` flag; hold counter `hcnt`.
- **States:** IDLE, EDIT_T, EDIT_A, LOAD_T, LOAD_A, STOP.
- **IDLE, button priority:** snooze > set > mode.
  - `btn_snooze` with `Alarm`=1: edit regs ← current time + `SNOOZE_MIN`; `snoozed`←1; go to STOP; then LOAD_A with the edit regs.
  - `btn_set` with `Alarm`=1: go to STOP. Afterwards, if `snoozed`, edit regs ← shadow, clear `snoozed`, go to LOAD_A; otherwise go to IDLE.
  - `btn_mode`: edit regs ← `H_out`/`M_out` on the same edge; digit←0; go to EDIT_T.
  - `btn_inc` in IDLE: ignored.
- **EDIT_T / EDIT_A, priority:** mode > set > inc.
  - `btn_mode` in EDIT_T: edit regs ← shadow; digit←0; go to EDIT_A.
  - `btn_mode` in EDIT_A: discard edits, go to IDLE.
  - `btn_set`: digit+1. On digit 3, go to LOAD_T (or LOAD_A, which also writes the edit regs into the shadow and clears `snoozed`).
  - `btn_inc`: increment the current digit with wrap.
    - H1: 0..2.
    - H0: 0..9, or 0..3 when H1=2.
    - M1: 0..5.
    - M0: 0..9.
    - H1 becoming 2 while H0>3 clamps H0 to 3.
- **LOAD_T / LOAD_A / STOP:**
  - The matching strobe is high for exactly `LD_HOLD` cycles.
  - `H_in`/`M_in` equal the edit regs throughout.
  - Buttons other than `al_toggle` are ignored.
- **Snooze arithmetic:** m = M1·10+M0+`SNOOZE_MIN`. If m ≥ 60, subtract 60 and increment the hour. Hour 24 wraps to 0. Results are converted back to BCD.
- **`al_toggle`:** acts in any state and flips `AL_ON`.
- **Outputs outside load states:** `H_in`/`M_in` always drive the edit regs. `edit_mode`/`edit_digit` reflect the state.
- **Reset:** mid-operation reset aborts any strobe immediately. Reset values:
  - all outputs 0;
  - state IDLE;
  - edit regs, shadow and `snoozed` 0;
  - `hcnt` 0.

## Timing
- A button sampled at edge N produces its state/digit change visible after edge N.
- Strobe rises after the edge that enters a LOAD/STOP state. It stays high for `LD_HOLD` cycles and falls on the same edge that leaves the state.
- The STOP→LOAD_A sequence has zero idle cycles between `STOP_al` falling and `LD_alarm` rising.
- Snooze/stop total latency is 2·`LD_HOLD`+1 cycles to IDLE. `busy` is high for that span minus the entry cycle.
- Edit capture of `H_out`/`M_out` uses the values present on the capturing edge.

## Test plan
- **Time set:** from reset, press mode, then set×4. Expect `LD_time` high 12 cycles with `H_in`=0,0 and `M_in`=0,0. Repeat with edits to 23:59 and expect the core to show 23:59:0x.
- **Digit wrap/clamp:**
  - H0=7, then inc H1 to 2: expect H0 clamped to 3.
  - Inc H1 past 2: expect 0.
  - M1 inc past 5: expect 0.
  - H0 with H1=2, inc past 3: expect 0.
- **Alarm set and abandon:** mode×2, edit the alarm to 07:30, set×4. Expect `LD_alarm` with 0,7,3,0 and the shadow updated. Mode×3 after edits: expect no strobe and the shadow unchanged.
- **Snooze:**
  - Time 23:58, alarm ringing, press snooze. Expect `STOP_al` for 12 cycles, then `LD_alarm` with 0,0,0,3.
  - Later, press set while ringing. Expect `STOP_al`, then `LD_alarm` with the shadow value, and `snoozed` cleared.
- **Priority/toggle:**
  - snooze+set in the same cycle in IDLE with `Alarm`=1: snooze wins.
  - `al_toggle` during LOAD_T: expect `AL_ON` flipped and the strobe unaffected.
- **Reset mid-strobe:** assert `reset` low at hold cycle 5. Expect all strobes 0 asynchronously, state IDLE, and `AL_ON` 0.
